// File: rtl/if_id_branch_ctrl_pkg.sv
// Shared constants for the decode-side branch/hazard controller: opcodes,
// condition codes, reset defaults and the B-offset helper.
package if_id_branch_ctrl_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;
  localparam int          PC_INC_DEF    = 4;
  localparam int          CNT_W_DEF     = 16;

  // Branch offsets are in half-words: sign-extend imm9 and scale by 2.
  function automatic logic [15:0] sext_imm9_x2(input logic [8:0] imm9);
    return {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/if_id_branch_ctrl_if.sv
// Fetch <-> decode link. Fetch drives the PC/instruction pair every cycle;
// decode answers with the redirect and freeze controls.
interface if_id_branch_ctrl_if;
  // Handshake: the fetched pair is consumed on a rising edge whenever
  // stall_de=0 (stall_de acts as an inverted ready). branch_en=1 redirects
  // fetch to branch_pc and the pair offered in that same cycle is dropped.
  logic [15:0] curr_pc_f;
  logic [15:0] curr_instr;
  logic        branch_en;
  logic [15:0] branch_pc;
  logic        stall_de;

  modport master (
    output curr_pc_f, curr_instr,
    input  branch_en, branch_pc, stall_de
  );

  modport slave (
    input  curr_pc_f, curr_instr,
    output branch_en, branch_pc, stall_de
  );
endinterface

// File: rtl/if_id_branch_ctrl_branch_cond_eval.sv
// Combinational evaluation of a 3-bit branch condition code against Z/V/N.
module branch_cond_eval
  import if_id_branch_ctrl_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       flag_z,
  input  logic       flag_v,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = !flag_z;
      CC_EQ:   taken = flag_z;
      CC_GT:   taken = !flag_z && !flag_n;
      CC_LT:   taken = flag_n;
      CC_GE:   taken = flag_z || !flag_n;
      CC_LE:   taken = flag_z || flag_n;
      CC_OV:   taken = flag_v;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_branch_ctrl.sv
// IF/ID pipeline register with decode-stage branch resolution, flag and
// load-use hazard stalls, sticky halt and saturating stall/flush counters.
module if_id_branch_ctrl
  import if_id_branch_ctrl_pkg::*;
#(
  parameter int          PC_INC    = PC_INC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  if_id_branch_ctrl_if.slave fetch,
  input  logic              flag_z,
  input  logic              flag_v,
  input  logic              flag_n,
  input  logic              ex_sets_flags,
  input  logic              ex_is_load,
  input  logic [3:0]        ex_rd,
  input  logic [15:0]       rs_data,
  output logic [3:0]        rs_addr,
  output logic [15:0]       instr_d,
  output logic [15:0]       pc_d,
  output logic              valid_d,
  output logic              halt_d,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic        is_b, is_br, is_branch;
  logic        reads_rs, reads_rt;
  logic        cond_true;
  logic        flag_haz, load_haz;
  logic        stall, take;
  logic [15:0] b_target;

  assign opcode  = instr_d[15:12];
  assign ccc     = instr_d[11:9];
  assign imm9    = instr_d[8:0];
  assign rs      = instr_d[7:4];
  assign rt      = instr_d[3:0];
  assign rs_addr = rs;

  assign is_b      = (opcode == OP_B);
  assign is_br     = (opcode == OP_BR);
  assign is_branch = is_b || is_br;
  assign reads_rs  = !(is_b || (opcode == OP_PCS) || (opcode == OP_HLT));
  assign reads_rt  = !opcode[3];

  branch_cond_eval u_cond (
    .ccc    (ccc),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n),
    .taken  (cond_true)
  );

  // Unconditional branches never wait on flags still being produced in EX.
  assign flag_haz = valid_d && is_branch && (ccc != CC_AL) && ex_sets_flags;
  assign load_haz = valid_d && ex_is_load &&
                    ((reads_rs && (rs == ex_rd)) || (reads_rt && (rt == ex_rd)));
  assign stall    = (flag_haz || load_haz || halt_d) && !rst;
  assign take     = valid_d && is_branch && cond_true && !stall && !rst;

  assign b_target = pc_d + 16'(PC_INC) + sext_imm9_x2(imm9);

  assign fetch.stall_de  = stall;
  assign fetch.branch_en = take;
  assign fetch.branch_pc = (take && is_br) ? rs_data : b_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= 16'h0000;
      valid_d   <= 1'b0;
      halt_d    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!stall) begin
        // A taken branch squashes the wrong-path word fetch offers this cycle.
        instr_d <= take ? NOP_INSTR : fetch.curr_instr;
        valid_d <= !take;
        pc_d    <= fetch.curr_pc_f;
      end
      if (valid_d && (opcode == OP_HLT) && !stall)
        halt_d <= 1'b1;
      if (stall && !halt_d && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (take && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_branch_ctrl.sv
// Directed self-checking bench for if_id_branch_ctrl; a second instance with
// 2-bit counters exercises counter saturation.
module tb_if_id_branch_ctrl;
  import if_id_branch_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flag_z, flag_v, flag_n;
  logic        ex_sets_flags, ex_is_load;
  logic [3:0]  ex_rd;
  logic [15:0] rs_data;

  logic [3:0]  rs_addr, rs_addr2;
  logic [15:0] instr_d, instr_d2, pc_d, pc_d2;
  logic        valid_d, valid_d2, halt_d, halt_d2;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  stall_cnt2, flush_cnt2;

  logic [2:0]  ce_ccc;
  logic        ce_z, ce_v, ce_n, ce_taken;

  int chk = 0;
  int err = 0;

  if_id_branch_ctrl_if fetch_if();
  if_id_branch_ctrl_if fetch2_if();

  if_id_branch_ctrl dut (
    .clk(clk), .rst(rst), .fetch(fetch_if),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .ex_sets_flags(ex_sets_flags), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .rs_data(rs_data), .rs_addr(rs_addr), .instr_d(instr_d), .pc_d(pc_d),
    .valid_d(valid_d), .halt_d(halt_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_branch_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .fetch(fetch2_if),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .ex_sets_flags(ex_sets_flags), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .rs_data(rs_data), .rs_addr(rs_addr2), .instr_d(instr_d2), .pc_d(pc_d2),
    .valid_d(valid_d2), .halt_d(halt_d2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  branch_cond_eval u_ce (
    .ccc(ce_ccc), .flag_z(ce_z), .flag_v(ce_v), .flag_n(ce_n), .taken(ce_taken)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [15:0] pc, input logic [15:0] ins);
    fetch_if.curr_pc_f  = pc;
    fetch_if.curr_instr = ins;
    fetch2_if.curr_pc_f  = pc;
    fetch2_if.curr_instr = ins;
  endtask

  task automatic clear_inputs();
    flag_z = 1'b0; flag_v = 1'b0; flag_n = 1'b0;
    ex_sets_flags = 1'b0; ex_is_load = 1'b0; ex_rd = 4'h0; rs_data = 16'h0000;
    set_fetch(16'h0000, 16'h0000);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_fetch(16'h0040, 16'hF000);
    tick();
    tick();
    chk++; if (instr_d !== 16'h0000) begin err++; $display("FAIL reset_instr_d got=%h exp=0000", instr_d); end
    chk++; if (pc_d !== 16'h0000) begin err++; $display("FAIL reset_pc_d got=%h exp=0000", pc_d); end
    chk++; if (valid_d !== 1'b0) begin err++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    chk++; if (halt_d !== 1'b0) begin err++; $display("FAIL reset_halt got=%b exp=0", halt_d); end
    chk++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin err++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    chk++; if (fetch_if.branch_en !== 1'b0 || fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL reset_ctrl got=%b%b exp=00", fetch_if.branch_en, fetch_if.stall_de); end
    rst = 1'b0;
  endtask

  task automatic test_cond_eval();
    // {ccc, z, v, n, expected_taken}
    logic [6:0] vec [12];
    vec = '{7'b000_000_1, 7'b000_100_0, 7'b001_100_1, 7'b010_000_1,
            7'b010_001_0, 7'b011_001_1, 7'b100_001_0, 7'b100_101_1,
            7'b101_000_0, 7'b110_010_1, 7'b110_101_0, 7'b111_000_1};
    for (int i = 0; i < 12; i++) begin
      ce_ccc = vec[i][6:4]; ce_z = vec[i][3]; ce_v = vec[i][2]; ce_n = vec[i][1];
      #1;
      chk++; if (ce_taken !== vec[i][0]) begin err++; $display("FAIL cond_eval[%0d] ccc=%b got=%b exp=%b", i, ce_ccc, ce_taken, vec[i][0]); end
    end
  endtask

  task automatic test_sequential();
    logic [15:0] pcs [3];
    logic [15:0] ins [3];
    pcs = '{16'h0000, 16'h0004, 16'h0008};
    ins = '{16'h0123, 16'h1456, 16'h2789};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_fetch(pcs[i], ins[i]);
      tick();
      chk++; if (pc_d !== pcs[i]) begin err++; $display("FAIL seq_pc_d[%0d] got=%h exp=%h", i, pc_d, pcs[i]); end
      chk++; if (instr_d !== ins[i] || valid_d !== 1'b1) begin err++; $display("FAIL seq_instr_d[%0d] got=%h/%b exp=%h/1", i, instr_d, valid_d, ins[i]); end
      chk++; if (fetch_if.branch_en !== 1'b0 || fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL seq_ctrl[%0d] got=%b%b exp=00", i, fetch_if.branch_en, fetch_if.stall_de); end
    end
  endtask

  task automatic test_b_taken();
    apply_reset();
    flag_z = 1'b1;
    set_fetch(16'h0010, 16'hC203);
    tick();
    set_fetch(16'h0014, 16'h0777);
    #1;
    chk++; if (fetch_if.branch_en !== 1'b1 || fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL beq_ctrl got=%b%b exp=10", fetch_if.branch_en, fetch_if.stall_de); end
    chk++; if (fetch_if.branch_pc !== 16'h001A) begin err++; $display("FAIL beq_target got=%h exp=001a", fetch_if.branch_pc); end
    tick();
    chk++; if (valid_d !== 1'b0 || instr_d !== 16'h0000) begin err++; $display("FAIL beq_flush got=%h/%b exp=0000/0", instr_d, valid_d); end
    chk++; if (pc_d !== 16'h0014) begin err++; $display("FAIL beq_flush_pc got=%h exp=0014", pc_d); end
    chk++; if (flush_cnt !== 16'd1 || fetch_if.branch_en !== 1'b0) begin err++; $display("FAIL beq_flush_cnt got=%0d/%b exp=1/0", flush_cnt, fetch_if.branch_en); end
  endtask

  task automatic test_not_taken();
    apply_reset();
    flag_z = 1'b1;
    set_fetch(16'h0100, 16'hC005);
    tick();
    #1;
    chk++; if (fetch_if.branch_en !== 1'b0) begin err++; $display("FAIL bne_not_taken got=%b exp=0", fetch_if.branch_en); end
    chk++; if (fetch_if.branch_pc !== 16'h010E) begin err++; $display("FAIL bne_idle_target got=%h exp=010e", fetch_if.branch_pc); end
  endtask

  task automatic test_flag_hazard();
    apply_reset();
    flag_z = 1'b1;
    set_fetch(16'h0010, 16'hC203);
    tick();
    ex_sets_flags = 1'b1;
    set_fetch(16'h0014, 16'h0777);
    #1;
    chk++; if (fetch_if.stall_de !== 1'b1 || fetch_if.branch_en !== 1'b0) begin err++; $display("FAIL fhaz_ctrl got=%b%b exp=01", fetch_if.branch_en, fetch_if.stall_de); end
    tick();
    chk++; if (pc_d !== 16'h0010 || instr_d !== 16'hC203 || valid_d !== 1'b1) begin err++; $display("FAIL fhaz_hold got=%h/%h/%b exp=0010/c203/1", pc_d, instr_d, valid_d); end
    chk++; if (stall_cnt !== 16'd1) begin err++; $display("FAIL fhaz_stall_cnt got=%0d exp=1", stall_cnt); end
    ex_sets_flags = 1'b0;
    #1;
    chk++; if (fetch_if.branch_en !== 1'b1 || fetch_if.branch_pc !== 16'h001A) begin err++; $display("FAIL fhaz_resolve got=%b/%h exp=1/001a", fetch_if.branch_en, fetch_if.branch_pc); end
    tick();
    chk++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1 || valid_d !== 1'b0) begin err++; $display("FAIL fhaz_after got=%0d/%0d/%b exp=1/1/0", flush_cnt, stall_cnt, valid_d); end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_is_load = 1'b1; ex_rd = 4'd3;
    set_fetch(16'h0020, 16'h0134);
    tick();
    set_fetch(16'h0024, 16'h0555);
    #1;
    chk++; if (fetch_if.stall_de !== 1'b1 || rs_addr !== 4'd3) begin err++; $display("FAIL luse_rs_stall got=%b/%h exp=1/3", fetch_if.stall_de, rs_addr); end
    tick();
    chk++; if (pc_d !== 16'h0020 || stall_cnt !== 16'd1) begin err++; $display("FAIL luse_hold got=%h/%0d exp=0020/1", pc_d, stall_cnt); end
    ex_is_load = 1'b0;
    #1;
    chk++; if (fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL luse_release got=%b exp=0", fetch_if.stall_de); end
    tick();
    chk++; if (pc_d !== 16'h0024 || instr_d !== 16'h0555) begin err++; $display("FAIL luse_proceed got=%h/%h exp=0024/0555", pc_d, instr_d); end
    ex_is_load = 1'b1; ex_rd = 4'd3;
    set_fetch(16'h0028, 16'h9013);
    tick();
    set_fetch(16'h002C, 16'h0013);
    #1;
    chk++; if (fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL luse_store_rt got=%b exp=0", fetch_if.stall_de); end
    tick();
    chk++; if (instr_d !== 16'h0013 || fetch_if.stall_de !== 1'b1) begin err++; $display("FAIL luse_alu_rt got=%h/%b exp=0013/1", instr_d, fetch_if.stall_de); end
    ex_is_load = 1'b0;
  endtask

  task automatic test_br_uncond();
    apply_reset();
    ex_sets_flags = 1'b1;
    rs_data = 16'h1234;
    set_fetch(16'h0040, 16'hDE50);
    tick();
    set_fetch(16'h0044, 16'h0777);
    #1;
    chk++; if (fetch_if.stall_de !== 1'b0 || fetch_if.branch_en !== 1'b1) begin err++; $display("FAIL br_ctrl got=%b%b exp=10", fetch_if.branch_en, fetch_if.stall_de); end
    chk++; if (fetch_if.branch_pc !== 16'h1234) begin err++; $display("FAIL br_target got=%h exp=1234", fetch_if.branch_pc); end
    apply_reset();
    set_fetch(16'h0000, 16'hCFFF);
    tick();
    #1;
    chk++; if (fetch_if.branch_en !== 1'b1 || fetch_if.branch_pc !== 16'h0002) begin err++; $display("FAIL b_neg_offset got=%b/%h exp=1/0002", fetch_if.branch_en, fetch_if.branch_pc); end
  endtask

  task automatic test_halt();
    apply_reset();
    set_fetch(16'h0050, 16'hF000);
    tick();
    set_fetch(16'h0054, 16'h0123);
    #1;
    chk++; if (halt_d !== 1'b0 || fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL halt_pre got=%b/%b exp=0/0", halt_d, fetch_if.stall_de); end
    tick();
    chk++; if (halt_d !== 1'b1 || pc_d !== 16'h0054) begin err++; $display("FAIL halt_set got=%b/%h exp=1/0054", halt_d, pc_d); end
    for (int i = 0; i < 12; i++) begin
      set_fetch(16'h0058 + 16'(i * 4), 16'hC203);
      flag_z = i[0];
      ex_sets_flags = i[1];
      #1;
      chk++; if (fetch_if.stall_de !== 1'b1 || fetch_if.branch_en !== 1'b0) begin err++; $display("FAIL halt_freeze[%0d] got=%b%b exp=01", i, fetch_if.branch_en, fetch_if.stall_de); end
      tick();
    end
    chk++; if (pc_d !== 16'h0054 || instr_d !== 16'h0123) begin err++; $display("FAIL halt_hold got=%h/%h exp=0054/0123", pc_d, instr_d); end
    chk++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin err++; $display("FAIL halt_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    rst = 1'b1;
    tick();
    chk++; if (halt_d !== 1'b0 || valid_d !== 1'b0 || pc_d !== 16'h0000 || instr_d !== 16'h0000) begin err++; $display("FAIL halt_rst got=%b/%b/%h/%h exp=0/0/0000/0000", halt_d, valid_d, pc_d, instr_d); end
    chk++; if (fetch_if.stall_de !== 1'b0 || fetch_if.branch_en !== 1'b0) begin err++; $display("FAIL halt_rst_ctrl got=%b%b exp=00", fetch_if.branch_en, fetch_if.stall_de); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_hlt_flushed();
    apply_reset();
    set_fetch(16'h0060, 16'hCE02);
    tick();
    set_fetch(16'h0064, 16'hF000);
    #1;
    chk++; if (fetch_if.branch_en !== 1'b1 || fetch_if.branch_pc !== 16'h0068) begin err++; $display("FAIL hltf_branch got=%b/%h exp=1/0068", fetch_if.branch_en, fetch_if.branch_pc); end
    tick();
    set_fetch(16'h0068, 16'h0123);
    tick();
    chk++; if (halt_d !== 1'b0 || fetch_if.stall_de !== 1'b0) begin err++; $display("FAIL hltf_no_halt got=%b/%b exp=0/0", halt_d, fetch_if.stall_de); end
    chk++; if (pc_d !== 16'h0068 || instr_d !== 16'h0123) begin err++; $display("FAIL hltf_target got=%h/%h exp=0068/0123", pc_d, instr_d); end
  endtask

  task automatic test_saturation();
    apply_reset();
    flag_z = 1'b1;
    set_fetch(16'h0010, 16'hC203);
    tick();
    ex_sets_flags = 1'b1;
    repeat (5) tick();
    chk++; if (stall_cnt !== 16'd5) begin err++; $display("FAIL sat_stall16 got=%0d exp=5", stall_cnt); end
    chk++; if (stall_cnt2 !== 2'd3) begin err++; $display("FAIL sat_stall2 got=%0d exp=3", stall_cnt2); end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_fetch(16'h0100 + 16'(i * 8), 16'hCE00);
      tick();
      set_fetch(16'h0104 + 16'(i * 8), 16'h0777);
      tick();
    end
    chk++; if (flush_cnt !== 16'd4) begin err++; $display("FAIL sat_flush16 got=%0d exp=4", flush_cnt); end
    chk++; if (flush_cnt2 !== 2'd3) begin err++; $display("FAIL sat_flush2 got=%0d exp=3", flush_cnt2); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    ce_ccc = 3'b000; ce_z = 1'b0; ce_v = 1'b0; ce_n = 1'b0;
    test_reset();
    test_cond_eval();
    test_sequential();
    test_b_taken();
    test_not_taken();
    test_flag_hazard();
    test_load_use();
    test_br_uncond();
    test_halt();
    test_hlt_flushed();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
